dsp_subsys: RTL and testbench

Streaming I/Q power-measurement block behind an AHB-Lite slave register port. It accepts 32-bit complex samples on an AXI-Stream slave, where I is bits [15:0] and Q is bits [31:16], both signed. For each frame it computes sample energy I²+Q², the 48-bit frame energy sum and the peak energy. An interrupt is raised on frame completion or when the peak reaches a threshold.

---
 rtl/dsp_subsys.sv | 193 +++++++++++++++++++
 tb/tb_dsp_subsys.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dsp_subsys.sv
// I/Q frame power meter: 3-stage sample pipeline (capture, energy, accumulate) behind an AHB-Lite register port.
// Define DSP_SUBSYS_PEAK_EN to build the peak tracker, PEAK register and OVER status.
module dsp_subsys #(
  parameter int          FRAME_LEN_RST = 1024,
  parameter logic [31:0] ID_VALUE      = 32'h44535031
) (
  input  logic        hclk,
  input  logic        hreset,
  input  logic        ce,
  input  logic [31:0] tdata_s,
  input  logic        tvalid_s,
  output logic        tready_s,
  input  logic [31:0] haddr_s,
  input  logic [2:0]  hburst_s,
  input  logic [2:0]  hsize_s,
  input  logic [1:0]  htrans_s,
  input  logic        hwrite_s,
  input  logic [31:0] hwdata_s,
  input  logic        hsel_s,
  output logic [31:0] hrdata_s,
  output logic        hreadyout_s,
  output logic        hresp_s,
  output logic        interrupts
);

  localparam logic [5:0] A_CTRL = 6'h00, A_STATUS = 6'h01, A_IRQ = 6'h02, A_FLEN = 6'h03,
                         A_THRESH = 6'h04, A_PLO = 6'h05, A_PHI = 6'h06, A_PEAK = 6'h07,
                         A_LAST = 6'h08, A_COUNT = 6'h09, A_ID = 6'h0A;

  logic        dp_valid, dp_write;
  logic [5:0]  dp_addr;
  logic        en, cont;
  logic [1:0]  status, irq_en;
  logic [15:0] frame_len, flen_eff, count;
  logic [31:0] thresh, last, peak_q, rd_data;
  logic [47:0] acc, acc_next, power;
  logic        wr, wr_ctrl, wr_status, clr, accept, frame_end, upd, done_set, over_set;
  logic        s1_vld, s1_last, s2_vld, s2_last;
  logic signed [15:0] s1_i, s1_q;
  logic signed [31:0] i_sq, q_sq;
  logic [31:0] energy, s2_e;
  logic        unused_ok;

  assign unused_ok   = ^{hburst_s, hsize_s, haddr_s[31:8], haddr_s[1:0], htrans_s[0]};
  assign hreadyout_s = 1'b1;
  assign hresp_s     = 1'b0;

  always_ff @(posedge hclk) begin
    if (hreset) begin
      dp_valid <= 1'b0;
      dp_write <= 1'b0;
      dp_addr  <= '0;
    end else begin
      dp_valid <= hsel_s & htrans_s[1];
      dp_write <= hwrite_s;
      dp_addr  <= haddr_s[7:2];
    end
  end

  assign wr        = dp_valid & dp_write;
  assign wr_ctrl   = wr && (dp_addr == A_CTRL);
  assign wr_status = wr && (dp_addr == A_STATUS);
  assign clr       = wr_ctrl & hwdata_s[1];

  assign flen_eff  = (frame_len == 16'd0) ? 16'd1 : frame_len;
  assign tready_s  = en & ce;
  assign accept    = tvalid_s & tready_s;
  assign frame_end = accept && (({1'b0, count} + 17'd1) >= {1'b0, flen_eff});

  always_ff @(posedge hclk) begin
    if (hreset) begin
      en        <= 1'b0;
      cont      <= 1'b0;
      irq_en    <= '0;
      frame_len <= 16'(FRAME_LEN_RST);
      thresh    <= 32'hFFFF_FFFF;
      status    <= '0;
      last      <= '0;
      count     <= '0;
    end else begin
      if (wr_ctrl) begin
        en   <= hwdata_s[0];
        cont <= hwdata_s[2];
      end else if (frame_end && !cont) begin
        en <= 1'b0;
      end
      if (wr && dp_addr == A_IRQ)    irq_en    <= hwdata_s[1:0];
      if (wr && dp_addr == A_FLEN)   frame_len <= hwdata_s[15:0];
      if (wr && dp_addr == A_THRESH) thresh    <= hwdata_s;
      // Hardware set is ORed in after the W1C mask so it wins a same-cycle clear
      status <= (status & ~(wr_status ? hwdata_s[1:0] : 2'b00)) | {over_set, done_set};
      if (accept) last <= tdata_s;
      if (clr)         count <= '0;
      else if (accept) count <= frame_end ? 16'd0 : count + 16'd1;
    end
  end

  assign i_sq   = 32'(s1_i) * 32'(s1_i);
  assign q_sq   = 32'(s1_q) * 32'(s1_q);
  assign energy = i_sq + q_sq;

  always_ff @(posedge hclk) begin
    if (hreset) begin
      s1_vld  <= 1'b0;
      s1_last <= 1'b0;
      s1_i    <= '0;
      s1_q    <= '0;
      s2_vld  <= 1'b0;
      s2_last <= 1'b0;
      s2_e    <= '0;
    end else if (clr) begin
      s1_vld <= 1'b0;
      s2_vld <= 1'b0;
    end else if (ce) begin
      s1_vld  <= accept;
      s1_last <= frame_end;
      if (accept) begin
        s1_i <= tdata_s[15:0];
        s1_q <= tdata_s[31:16];
      end
      s2_vld  <= s1_vld;
      s2_last <= s1_last;
      if (s1_vld) s2_e <= energy;
    end
  end

  assign upd      = ce & s2_vld & ~clr;
  assign done_set = upd & s2_last;
  assign acc_next = acc + {16'd0, s2_e};

  always_ff @(posedge hclk) begin
    if (hreset) begin
      acc   <= '0;
      power <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (upd) begin
      if (s2_last) begin
        power <= acc_next;
        acc   <= '0;
      end else begin
        acc <= acc_next;
      end
    end
  end

`ifdef DSP_SUBSYS_PEAK_EN
  logic [31:0] run_peak, peak_next;
  assign peak_next = (s2_e > run_peak) ? s2_e : run_peak;
  assign over_set  = done_set && (peak_next >= thresh);

  always_ff @(posedge hclk) begin
    if (hreset) begin
      run_peak <= '0;
      peak_q   <= '0;
    end else if (clr) begin
      run_peak <= '0;
    end else if (upd) begin
      if (s2_last) begin
        peak_q   <= peak_next;
        run_peak <= '0;
      end else begin
        run_peak <= peak_next;
      end
    end
  end
`else
  assign peak_q   = '0;
  assign over_set = 1'b0;
`endif

  assign interrupts = |(status & irq_en);

  always_comb begin
    rd_data = '0;
    case (dp_addr)
      A_CTRL:   rd_data = {29'd0, cont, 1'b0, en};
      A_STATUS: rd_data = {30'd0, status};
      A_IRQ:    rd_data = {30'd0, irq_en};
      A_FLEN:   rd_data = {16'd0, frame_len};
      A_THRESH: rd_data = thresh;
      A_PLO:    rd_data = power[31:0];
      A_PHI:    rd_data = {16'd0, power[47:32]};
      A_PEAK:   rd_data = peak_q;
      A_LAST:   rd_data = last;
      A_COUNT:  rd_data = {16'd0, count};
      A_ID:     rd_data = ID_VALUE;
      default:  rd_data = '0;
    endcase
    hrdata_s = (dp_valid & ~dp_write) ? rd_data : 32'd0;
  end

endmodule

// File: tb/tb_dsp_subsys.sv
// Randomized self-checking bench for dsp_subsys; frame energy/peak expectations come from plain arithmetic on the sent samples.
module tb_dsp_subsys;

`ifdef DSP_SUBSYS_PEAK_EN
  localparam bit PEAK_EN = 1'b1;
`else
  localparam bit PEAK_EN = 1'b0;
`endif

  logic        hclk = 1'b0;
  logic        hreset, ce, tvalid_s, tready_s, hwrite_s, hsel_s, hreadyout_s, hresp_s, interrupts;
  logic [31:0] tdata_s, haddr_s, hwdata_s, hrdata_s;
  logic [2:0]  hburst_s, hsize_s;
  logic [1:0]  htrans_s;

  int n_checks = 0;
  int n_pass   = 0;
  int bad_resp = 0;
  logic [31:0] q_data[$];

  dsp_subsys dut (
    .hclk(hclk), .hreset(hreset), .ce(ce),
    .tdata_s(tdata_s), .tvalid_s(tvalid_s), .tready_s(tready_s),
    .haddr_s(haddr_s), .hburst_s(hburst_s), .hsize_s(hsize_s), .htrans_s(htrans_s),
    .hwrite_s(hwrite_s), .hwdata_s(hwdata_s), .hsel_s(hsel_s),
    .hrdata_s(hrdata_s), .hreadyout_s(hreadyout_s), .hresp_s(hresp_s),
    .interrupts(interrupts)
  );

  always #5 hclk = ~hclk;

  always @(negedge hclk) if (hresp_s !== 1'b0 || hreadyout_s !== 1'b1) bad_resp++;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge hclk);
    #1;
  endtask

  task automatic ahb_write(input logic [7:0] a, input logic [31:0] d);
    @(posedge hclk); #1;
    hsel_s = 1'b1; htrans_s = 2'b10; hwrite_s = 1'b1; haddr_s = {24'd0, a};
    @(posedge hclk); #1;
    hsel_s = 1'b0; htrans_s = 2'b00; hwrite_s = 1'b0; hwdata_s = d;
    @(posedge hclk); #1;
  endtask

  task automatic ahb_read(input logic [7:0] a, output logic [31:0] d);
    @(posedge hclk); #1;
    hsel_s = 1'b1; htrans_s = 2'b10; hwrite_s = 1'b0; haddr_s = {24'd0, a};
    @(posedge hclk); #1;
    hsel_s = 1'b0; htrans_s = 2'b00;
    d = hrdata_s;
  endtask

  task automatic ahb_wr_rd(input logic [7:0] a, input logic [31:0] wd, output logic [31:0] rd);
    @(posedge hclk); #1;
    hsel_s = 1'b1; htrans_s = 2'b10; hwrite_s = 1'b1; haddr_s = {24'd0, a};
    @(posedge hclk); #1;
    hwdata_s = wd; hwrite_s = 1'b0;
    @(posedge hclk); #1;
    hsel_s = 1'b0; htrans_s = 2'b00;
    rd = hrdata_s;
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] a, input logic [31:0] exp);
    logic [31:0] d;
    ahb_read(a, d);
    chk(tag, {32'd0, d}, {32'd0, exp});
  endtask

  // Holds one sample on the stream until the DUT takes it; ce may be dithered meanwhile.
  task automatic send_sample(input logic [31:0] d, input bit rand_ce);
    bit taken = 1'b0;
    for (int t = 0; t < 64 && !taken; t++) begin
      tvalid_s = 1'b1; tdata_s = d;
      ce = rand_ce ? ($urandom_range(0, 2) != 0) : 1'b1;
      #1;
      taken = tready_s;
      @(posedge hclk); #1;
    end
    tvalid_s = 1'b0; ce = 1'b1;
    if (!taken) chk("send_timeout", 64'd0, 64'd1);
  endtask

  function automatic longint energy_of(input logic [31:0] d);
    logic signed [15:0] iv, qv;
    iv = d[15:0];
    qv = d[31:16];
    return longint'(iv) * longint'(iv) + longint'(qv) * longint'(qv);
  endfunction

  task automatic send_frame(input int n, input bit rand_ce, output longint sum, output longint pk);
    logic [31:0] d;
    sum = 0; pk = 0;
    q_data.delete();
    for (int k = 0; k < n; k++) begin
      d = ($urandom_range(0, 3) == 0) ? 32'h8000_8000 : $urandom;
      q_data.push_back(d);
      send_sample(d, rand_ce);
    end
    foreach (q_data[k]) begin
      sum = (sum + energy_of(q_data[k])) & 64'h0000_FFFF_FFFF_FFFF;
      if (energy_of(q_data[k]) > pk) pk = energy_of(q_data[k]);
    end
  endtask

  initial begin
    logic [31:0] d;
    longint sum, pk, th;
    int flen, eff, drops;

    hreset = 1'b1; ce = 1'b1; tvalid_s = 1'b0; tdata_s = '0;
    haddr_s = '0; hburst_s = '0; hsize_s = 3'd2; htrans_s = '0;
    hwrite_s = 1'b0; hwdata_s = '0; hsel_s = 1'b0;
    idle(3);
    hreset = 1'b0;

    chk("rst_tready", {63'd0, tready_s}, 64'd0);
    chk("rst_irq", {63'd0, interrupts}, 64'd0);
    chk("rst_hrdata", {32'd0, hrdata_s}, 64'd0);
    rd_chk("rst_id", 8'h28, 32'h4453_5031);
    rd_chk("rst_flen", 8'h0C, 32'd1024);
    rd_chk("rst_thresh", 8'h10, 32'hFFFF_FFFF);
    rd_chk("rst_ctrl", 8'h00, 32'd0);
    rd_chk("rst_status", 8'h04, 32'd0);

    // Four samples of I=3,Q=4 make a 4-sample frame
    ahb_write(8'h0C, 32'd4);
    ahb_write(8'h08, 32'd1);
    ahb_write(8'h00, 32'd1);
    for (int k = 0; k < 4; k++) send_sample(32'h0004_0003, 1'b0);
    idle(4);
    rd_chk("f1_power_lo", 8'h14, 32'd100);
    rd_chk("f1_power_hi", 8'h18, 32'd0);
    rd_chk("f1_peak", 8'h1C, PEAK_EN ? 32'd25 : 32'd0);
    rd_chk("f1_status", 8'h04, 32'd1);
    chk("f1_irq", {63'd0, interrupts}, 64'd1);
    rd_chk("f1_ctrl", 8'h00, 32'd0);
    chk("f1_tready", {63'd0, tready_s}, 64'd0);
    rd_chk("f1_last", 8'h20, 32'h0004_0003);

    // Threshold hit on the peak
    ahb_write(8'h04, 32'd3);
    ahb_write(8'h10, 32'd25);
    ahb_write(8'h08, 32'd2);
    ahb_write(8'h00, 32'd1);
    for (int k = 0; k < 4; k++) send_sample(32'h0004_0003, 1'b0);
    idle(4);
    rd_chk("f2_status", 8'h04, PEAK_EN ? 32'd3 : 32'd1);
    chk("f2_irq", {63'd0, interrupts}, PEAK_EN ? 64'd1 : 64'd0);
    ahb_write(8'h04, 32'd3);
    rd_chk("f2_w1c_status", 8'h04, 32'd0);
    chk("f2_w1c_irq", {63'd0, interrupts}, 64'd0);

    // Random frames, random lengths (0 means 1), ce dithered
    ahb_write(8'h08, 32'd3);
    for (int it = 0; it < 6; it++) begin
      flen = $urandom_range(0, 6);
      eff  = (flen == 0) ? 1 : flen;
      th   = longint'($urandom_range(0, 32'h8000_0000));
      ahb_write(8'h04, 32'd3);
      ahb_write(8'h0C, 32'(flen));
      ahb_write(8'h10, 32'(th));
      ahb_write(8'h00, 32'd1);
      send_frame(eff, 1'b1, sum, pk);
      idle(4);
      rd_chk($sformatf("rf%0d_power_lo", it), 8'h14, sum[31:0]);
      rd_chk($sformatf("rf%0d_power_hi", it), 8'h18, {16'd0, sum[47:32]});
      rd_chk($sformatf("rf%0d_peak", it), 8'h1C, PEAK_EN ? pk[31:0] : 32'd0);
      rd_chk($sformatf("rf%0d_status", it), 8'h04, (PEAK_EN && pk >= th) ? 32'd3 : 32'd1);
      rd_chk($sformatf("rf%0d_count", it), 8'h24, 32'd0);
      rd_chk($sformatf("rf%0d_ctrl", it), 8'h00, 32'd0);
      chk($sformatf("rf%0d_irq", it), {63'd0, interrupts}, 64'd1);
    end

    // Continuous mode at full scale: each 2-sample frame sums to 2^32
    ahb_write(8'h04, 32'd3);
    ahb_write(8'h10, 32'hFFFF_FFFF);
    ahb_write(8'h0C, 32'd2);
    ahb_write(8'h00, 32'd5);
    drops = 0;
    tvalid_s = 1'b1; tdata_s = 32'h8000_8000;
    for (int k = 0; k < 10; k++) begin
      if (tready_s !== 1'b1) drops++;
      @(posedge hclk); #1;
    end
    tvalid_s = 1'b0;
    chk("cont_tready_drops", 64'(drops), 64'd0);
    idle(4);
    rd_chk("cont_power_lo", 8'h14, 32'd0);
    rd_chk("cont_power_hi", 8'h18, 32'd1);
    rd_chk("cont_peak", 8'h1C, PEAK_EN ? 32'h8000_0000 : 32'd0);
    rd_chk("cont_ctrl", 8'h00, 32'd5);
    rd_chk("cont_count", 8'h24, 32'd0);
    ahb_write(8'h00, 32'd0);

    // CLR while a sample is on the bus: counter and accumulator restart
    ahb_write(8'h04, 32'd3);
    ahb_write(8'h0C, 32'd8);
    ahb_write(8'h00, 32'd1);
    send_frame(3, 1'b0, sum, pk);
    tvalid_s = 1'b1; tdata_s = 32'h0007_0005;
    ahb_write(8'h00, 32'd3);
    tvalid_s = 1'b0;
    rd_chk("clr_count", 8'h24, 32'd0);
    rd_chk("clr_last", 8'h20, 32'h0007_0005);
    rd_chk("clr_status", 8'h04, 32'd0);
    send_frame(8, 1'b1, sum, pk);
    idle(4);
    rd_chk("clr_power_lo", 8'h14, sum[31:0]);
    rd_chk("clr_power_hi", 8'h18, {16'd0, sum[47:32]});
    rd_chk("clr_done", 8'h04, (PEAK_EN && pk >= 64'hFFFF_FFFF) ? 32'd3 : 32'd1);

    // Software stop mid-frame: no DONE, count held
    ahb_write(8'h04, 32'd3);
    ahb_write(8'h00, 32'd1);
    send_frame(3, 1'b0, sum, pk);
    ahb_write(8'h00, 32'd0);
    idle(4);
    rd_chk("stop_status", 8'h04, 32'd0);
    rd_chk("stop_count", 8'h24, 32'd3);
    chk("stop_tready", {63'd0, tready_s}, 64'd0);
    ahb_write(8'h00, 32'd2);
    rd_chk("stop_clr_count", 8'h24, 32'd0);

    // Unmapped offset and back-to-back write/read
    ahb_write(8'h3C, 32'hDEAD_BEEF);
    rd_chk("unmapped", 8'h3C, 32'd0);
    ahb_wr_rd(8'h10, 32'h1234_5678, d);
    chk("b2b_thresh", {32'd0, d}, 64'h1234_5678);

    // Reset in the middle of a frame
    ahb_write(8'h00, 32'd1);
    send_frame(2, 1'b0, sum, pk);
    @(posedge hclk); #1;
    hreset = 1'b1;
    @(posedge hclk); #1;
    hreset = 1'b0;
    chk("mrst_tready", {63'd0, tready_s}, 64'd0);
    chk("mrst_irq", {63'd0, interrupts}, 64'd0);
    rd_chk("mrst_count", 8'h24, 32'd0);
    rd_chk("mrst_flen", 8'h0C, 32'd1024);
    rd_chk("mrst_thresh", 8'h10, 32'hFFFF_FFFF);
    rd_chk("mrst_irq_en", 8'h08, 32'd0);

    chk("ahb_resp_const", 64'(bad_resp), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
